// File: rtl/sync_filter_pkg.sv
// Shared constants and helpers for the sync_filter input conditioner.
// Holds the parameter lower bounds and the filter-counter width rule.
package sync_filter_pkg;

    localparam int MIN_WIDTH         = 1;
    localparam int MIN_SYNC_STAGES   = 2;
    localparam int MIN_FILTER_CYCLES = 1;

    // Counter must hold 0..cycles-1; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// One conditioner channel: synchronizer chain, stability counter, and a
// registered level with single-cycle rise/fall pulses.
module sync_filter_chan
    import sync_filter_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int             CW       = cnt_width(FILTER_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // The chain keeps shifting while en is low so the filter resumes on fresh data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            dout  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (en) begin
                if (s == dout) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_LAST) begin
                    dout  <= s;
                    cnt_q <= '0;
                    rise  <= s;
                    fall  <= ~s;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sync_filter.sv
// Multi-channel input conditioner: WIDTH independent synchronize-and-debounce
// channels with level and edge-pulse outputs.
module sync_filter
    import sync_filter_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    if (WIDTH < MIN_WIDTH) begin : g_bad_width
        $error("sync_filter: WIDTH must be at least %0d", MIN_WIDTH);
    end
    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
        $error("sync_filter: SYNC_STAGES must be at least %0d", MIN_SYNC_STAGES);
    end
    if (FILTER_CYCLES < MIN_FILTER_CYCLES) begin : g_bad_filter
        $error("sync_filter: FILTER_CYCLES must be at least %0d", MIN_FILTER_CYCLES);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        sync_filter_chan #(
            .SYNC_STAGES   (SYNC_STAGES),
            .FILTER_CYCLES (FILTER_CYCLES)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .din   (din[i]),
            .dout  (dout[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

endmodule

// File: tb/tb_sync_filter.sv
// Bench for sync_filter: a filtered instance (4 ch, 2 sync, 3 cycles) and a
// bypass instance (4 ch, 3 sync, 1 cycle) driven from hand-derived vectors.
module tb_sync_filter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] din, din_b;
    logic [3:0] dout, rise, fall;
    logic [3:0] dout_b, rise_b, fall_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sync_filter #(.WIDTH(4), .SYNC_STAGES(2), .FILTER_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din),
        .dout(dout), .rise(rise), .fall(fall)
    );

    sync_filter #(.WIDTH(4), .SYNC_STAGES(3), .FILTER_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din_b),
        .dout(dout_b), .rise(rise_b), .fall(fall_b)
    );

    typedef struct {
        logic       sel;
        logic [3:0] dout;
        logic [3:0] rise;
        logic [3:0] fall;
    } exp_t;

    typedef struct {
        logic       en;
        logic [3:0] din;
        int         n;
        logic [3:0] dout;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;

    localparam int NV = 33;
    vec_t vecs [0:NV-1];
    exp_t sbq [$];

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Drive one cycle of stimulus, queue the expectation, compare after the edge.
    task automatic cyc(input logic e, input logic [3:0] da, input logic [3:0] db,
                       input exp_t x, input string nm);
        exp_t y;
        en    = e;
        din   = da;
        din_b = db;
        sbq.push_back(x);
        @(posedge clk);
        #1;
        y = sbq.pop_front();
        if (y.sel == 1'b0) begin
            chk({nm, " dout"}, dout, y.dout);
            chk({nm, " rise"}, rise, y.rise);
            chk({nm, " fall"}, fall, y.fall);
        end else begin
            chk({nm, " dout_b"}, dout_b, y.dout);
            chk({nm, " rise_b"}, rise_b, y.rise);
            chk({nm, " fall_b"}, fall_b, y.fall);
        end
    endtask

    function automatic exp_t ea(input logic [3:0] d, input logic [3:0] r, input logic [3:0] f);
        exp_t x;
        x.sel = 1'b0; x.dout = d; x.rise = r; x.fall = f;
        return x;
    endfunction

    function automatic exp_t eb(input logic [3:0] d, input logic [3:0] r, input logic [3:0] f);
        exp_t x;
        x.sel = 1'b1; x.dout = d; x.rise = r; x.fall = f;
        return x;
    endfunction

    initial begin
        // en, din, cycles, dout, rise, fall  (expectation holds for every cycle)
        vecs = '{
            '{1'b1, 4'h0, 2, 4'h0, 4'h0, 4'h0},
            '{1'b1, 4'h1, 4, 4'h0, 4'h0, 4'h0},   // step up
            '{1'b1, 4'h1, 1, 4'h1, 4'h1, 4'h0},
            '{1'b1, 4'h1, 1, 4'h1, 4'h0, 4'h0},
            '{1'b1, 4'h0, 4, 4'h1, 4'h0, 4'h0},   // step down
            '{1'b1, 4'h0, 1, 4'h0, 4'h0, 4'h1},
            '{1'b1, 4'h0, 1, 4'h0, 4'h0, 4'h0},
            '{1'b1, 4'h4, 2, 4'h0, 4'h0, 4'h0},   // 2-cycle glitch
            '{1'b1, 4'h0, 4, 4'h0, 4'h0, 4'h0},
            '{1'b1, 4'h4, 3, 4'h0, 4'h0, 4'h0},   // 3-cycle pulse accepted
            '{1'b1, 4'h0, 1, 4'h0, 4'h0, 4'h0},
            '{1'b1, 4'h0, 1, 4'h4, 4'h4, 4'h0},
            '{1'b1, 4'h0, 2, 4'h4, 4'h0, 4'h0},
            '{1'b1, 4'h0, 1, 4'h0, 4'h0, 4'h4},
            '{1'b1, 4'h0, 1, 4'h0, 4'h0, 4'h0},
            '{1'b1, 4'h8, 4, 4'h0, 4'h0, 4'h0},
            '{1'b1, 4'h8, 1, 4'h8, 4'h8, 4'h0},
            '{1'b1, 4'h8, 1, 4'h8, 4'h0, 4'h0},
            '{1'b1, 4'h1, 4, 4'h8, 4'h0, 4'h0},   // ch0 rises, ch3 falls together
            '{1'b1, 4'h1, 1, 4'h1, 4'h1, 4'h8},
            '{1'b1, 4'h1, 1, 4'h1, 4'h0, 4'h0},
            '{1'b1, 4'h0, 4, 4'h1, 4'h0, 4'h0},
            '{1'b1, 4'h0, 1, 4'h0, 4'h0, 4'h1},
            '{1'b1, 4'h0, 1, 4'h0, 4'h0, 4'h0},
            '{1'b1, 4'h1, 4, 4'h0, 4'h0, 4'h0},   // count reaches 2
            '{1'b0, 4'h1, 5, 4'h0, 4'h0, 4'h0},   // frozen
            '{1'b1, 4'h1, 1, 4'h1, 4'h1, 4'h0},   // resumes, accepts at once
            '{1'b1, 4'h1, 1, 4'h1, 4'h0, 4'h0},
            '{1'b1, 4'h0, 4, 4'h1, 4'h0, 4'h0},   // count reaches 2
            '{1'b0, 4'h1, 3, 4'h1, 4'h0, 4'h0},   // input returns while frozen
            '{1'b1, 4'h1, 1, 4'h1, 4'h0, 4'h0},   // match clears the count
            '{1'b1, 4'h0, 4, 4'h1, 4'h0, 4'h0},   // needs the full window again
            '{1'b1, 4'h0, 1, 4'h0, 4'h0, 4'h1}
        };

        rst_n = 1'b0;
        en    = 1'b1;
        din   = 4'hF;
        din_b = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("in_reset dout", dout, 4'h0);
        chk("in_reset rise", rise, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) cyc(1'b1, 4'hF, 4'h0, ea(4'h0, 4'h0, 4'h0), $sformatf("rel%0d", k));
        cyc(1'b1, 4'hF, 4'h0, ea(4'hF, 4'hF, 4'h0), "rel4");

        // Asynchronous assert while rise is high must clear everything at once.
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst dout", dout, 4'h0);
        chk("async_rst rise", rise, 4'h0);
        chk("async_rst fall", fall, 4'h0);
        din = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < NV; v++) begin
            for (int c = 0; c < vecs[v].n; c++) begin
                cyc(vecs[v].en, vecs[v].din, 4'h0,
                    ea(vecs[v].dout, vecs[v].rise, vecs[v].fall),
                    $sformatf("vec%0d.%0d", v, c));
            end
        end

        // Bypass instance: 3-edge latency, single-cycle pulse passes through.
        for (int k = 0; k < 3; k++) cyc(1'b1, 4'h0, 4'h5, eb(4'h0, 4'h0, 4'h0), $sformatf("byp%0d", k));
        cyc(1'b1, 4'h0, 4'h5, eb(4'h5, 4'h5, 4'h0), "byp3");
        cyc(1'b1, 4'h0, 4'h5, eb(4'h5, 4'h0, 4'h0), "byp4");
        cyc(1'b1, 4'h0, 4'h7, eb(4'h5, 4'h0, 4'h0), "bpulse0");
        cyc(1'b1, 4'h0, 4'h5, eb(4'h5, 4'h0, 4'h0), "bpulse1");
        cyc(1'b1, 4'h0, 4'h5, eb(4'h5, 4'h0, 4'h0), "bpulse2");
        cyc(1'b1, 4'h0, 4'h5, eb(4'h7, 4'h2, 4'h0), "bpulse3");
        cyc(1'b1, 4'h0, 4'h5, eb(4'h5, 4'h0, 4'h2), "bpulse4");
        cyc(1'b1, 4'h0, 4'h5, eb(4'h5, 4'h0, 4'h0), "bpulse5");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
